uart_transmit: RTL and testbench
================================

Name: uart_transmit

Overview:
- 8N1 asynchronous serial transmitter. Counterpart of the team's serial receive block; drives the `tx` line of the board UART.
- Bytes enter through a valid/ready handshake into a small FIFO and are serialized LSB first.
- Timing is in clock cycles per bit, with the same parameterization as the receiver, so the two loop back directly.

Parameters:
- clockperbit, 10, clock cycles per serial bit. Must be >= 2.
- stopbits, 1, number of stop bits per frame (1 or 2).
- fifodepth, 4, FIFO entries. Power of 2, >= 2.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- txdata  input  8  byte to send; sampled when `txstart` && `txready`.
- txstart  input  1  valid strobe for `txdata`.
- txready  output  1  FIFO not full; a write is accepted only when high.
- tx  output  1  serial line, registered, idles high.
- txbusy  output  1  high while a frame (start..stop) is being driven.
- txfinish  output  1  high when FIFO is empty and FSM is IDLE. Same sense as the receiver's finish flag.

Behaviour:
- Reset (`reset`==0, asynchronous):
  - Outputs: `tx`=1, `txbusy`=0, `txready`=1, `txfinish`=1.
  - Internals: FSM=IDLE, FIFO pointers and count cleared, bit timer=0, bit index=0.
  - Reset mid-frame aborts the frame; the line returns high immediately, with no partial stop bit.
- FIFO:
  - Write on edge where `txstart` && `txready`.
  - `txready` = (count != fifodepth), combinational from count.
  - A push attempt while full is ignored, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full leaves count unchanged.
  - Pointers wrap modulo fifodepth.
- FSM states:
  - IDLE:
    - If FIFO non-empty: pop the head into the 8-bit shift register, `tx`<=0, timer<=clockperbit-1, go to START.
    - Else hold `tx`=1.
  - START: when timer==0, `tx`<=shift[0], index<=0, timer<=clockperbit-1, go to DATA. Else timer-1.
  - DATA:
    - When timer==0 and index<7: shift right, `tx`<=next bit, index+1, timer reload.
    - When timer==0 and index==7: `tx`<=1, timer<=clockperbit*stopbits-1, go to STOP.
  - STOP: when timer==0:
    - If FIFO non-empty: pop, `tx`<=0, go to START (back-to-back, no idle gap).
    - Else go to IDLE.
- Timing:
  - Each bit is exactly clockperbit cycles. The stop period is clockperbit*stopbits cycles.
  - Frame length is (9+stopbits)*clockperbit cycles.
- Latency: with FSM IDLE and FIFO empty, a byte accepted at edge E0 is popped at E1, and `tx` falls after E1.
- `txbusy` = FSM != IDLE (registered state decode).
- `txfinish` = FSM==IDLE && count==0.
  - It drops the edge after an accept into an empty FIFO.
  - It rises at the end of the last stop bit.
- Timer width: $clog2(clockperbit*stopbits) bits; no overflow permitted.
- `txdata` changing while not accepted has no effect. FIFO contents are stable once written.

Test Plan:
- Single byte: clockperbit=10, push 0x55 when idle.
  - `tx` falls 1 cycle after accept.
  - Line shows 0,1,0,1,0,1,0,1,0,1, each 10 cycles.
  - `txfinish` returns 1 exactly 100 cycles after the fall.
- Back-to-back: push 0xA5, 0x0F, 0xFF on consecutive cycles.
  - Three frames with no idle gap; each start bit follows the previous stop bit immediately.
  - Total 300 cycles; the decoded bytes match.
- Full FIFO: with the FSM busy, push 4 bytes, then a 5th.
  - `txready`=0 after the 4th; the 5th is dropped.
  - Exactly bytes 1..4 (plus the in-flight byte) appear on `tx`.
- Reset mid-frame: assert `reset`=0 during the DATA bit 3 of 0x00.
  - `tx`=1 asynchronously; `txbusy`=0, `txready`=1, `txfinish`=1.
  - After release, a new byte 0x3C transmits correctly.
- stopbits=2: send 0x81.
  - Stop period is 20 cycles; frame is 110 cycles.
  - A queued second byte starts exactly at cycle 110.
- Loopback: connect `tx` to the receive block's `rx` (same clockperbit) and stream 256 bytes 0x00..0xFF.
  - The receiver's data register matches each byte on its finish flag; no framing slips.

Source files
------------

// File: rtl/uart_transmit.sv
// -----------------------------------------------------------------------------
// uart_transmit
//
// 8N1 asynchronous serial transmitter. Bytes are queued in a small FIFO and
// shifted out LSB first, framed by one start bit (0) and stopbits stop bits
// (1). Bit timing is counted in clock cycles, so a receiver built with the
// same clockperbit loops back directly.
//
// Parameters
//   clockperbit : clock cycles per serial bit (>= 2)
//   stopbits    : stop bits per frame (1 or 2)
//   fifodepth   : FIFO entries (power of 2, >= 2)
//
// Ports
//   clock    in   system clock, rising edge
//   reset    in   asynchronous reset, active low
//   txdata   in   byte to send
//   txstart  in   valid strobe for txdata
//   txready  out  FIFO not full
//   tx       out  registered serial line, idles high
//   txbusy   out  a frame (start..stop) is being driven
//   txfinish out  FIFO empty and transmitter idle
//
// Handshake: txdata is written into the FIFO on a rising edge where
// txstart && txready. txready depends only on the FIFO fill level, never on
// txstart, so a source may hold txstart high and wait for txready. When
// txready is low the offered byte is ignored and must be offered again.
// -----------------------------------------------------------------------------
module uart_transmit #(
   parameter int clockperbit = 10,
   parameter int stopbits    = 1,
   parameter int fifodepth   = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] txdata,
   input  logic       txstart,
   output logic       txready,
   output logic       tx,
   output logic       txbusy,
   output logic       txfinish
);

   // The stop period is the longest interval the timer has to count, so it
   // sets the timer width; a single bit period always fits as well.
   localparam int STOP_CYCLES = clockperbit * stopbits;
   localparam int TW          = $clog2(STOP_CYCLES);
   localparam int AW          = $clog2(fifodepth);
   localparam int CW          = AW + 1;

   localparam logic [TW-1:0] BIT_RELOAD  = TW'(clockperbit - 1);
   localparam logic [TW-1:0] STOP_RELOAD = TW'(STOP_CYCLES - 1);
   localparam logic [CW-1:0] FULL_COUNT  = CW'(fifodepth);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // ---------------------------------------------------------------------------
   // FIFO
   // ---------------------------------------------------------------------------
   logic [7:0]    mem_q [fifodepth];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          push;
   logic          pop;
   logic [7:0]    head;

   assign txready = (count_q != FULL_COUNT);
   // A push while full is dropped here, even if the FSM pops in the same cycle.
   assign push    = txstart && txready;
   assign head    = mem_q[rd_ptr_q];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         // Pointers wrap naturally because fifodepth is a power of 2.
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage carries no reset: an entry is only read after it was written.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= txdata;
      end
   end

   // ---------------------------------------------------------------------------
   // Serializer FSM
   // ---------------------------------------------------------------------------
   state_t        state_q;
   logic [TW-1:0] timer_q;
   logic [2:0]    index_q;
   logic [7:0]    shift_q;
   logic          tx_q;

   // A byte leaves the FIFO either from IDLE or at the very end of a stop
   // period; the latter gives back-to-back frames with no idle gap.
   always_comb begin
      pop = 1'b0;
      if (count_q != '0) begin
         if (state_q == IDLE) begin
            pop = 1'b1;
         end else if ((state_q == STOP) && (timer_q == '0)) begin
            pop = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         timer_q <= '0;
         index_q <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (pop) begin
                  shift_q <= head;
                  tx_q    <= 1'b0;
                  timer_q <= BIT_RELOAD;
                  state_q <= START;
               end else begin
                  tx_q <= 1'b1;
               end
            end

            START: begin
               if (timer_q == '0) begin
                  tx_q    <= shift_q[0];
                  index_q <= '0;
                  timer_q <= BIT_RELOAD;
                  state_q <= DATA;
               end else begin
                  timer_q <= timer_q - 1'b1;
               end
            end

            DATA: begin
               if (timer_q == '0) begin
                  if (index_q != 3'd7) begin
                     // shift_q[0] is on the line now; shift_q[1] goes next.
                     shift_q <= {1'b0, shift_q[7:1]};
                     tx_q    <= shift_q[1];
                     index_q <= index_q + 3'd1;
                     timer_q <= BIT_RELOAD;
                  end else begin
                     tx_q    <= 1'b1;
                     timer_q <= STOP_RELOAD;
                     state_q <= STOP;
                  end
               end else begin
                  timer_q <= timer_q - 1'b1;
               end
            end

            STOP: begin
               if (timer_q == '0) begin
                  if (pop) begin
                     shift_q <= head;
                     tx_q    <= 1'b0;
                     timer_q <= BIT_RELOAD;
                     state_q <= START;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  timer_q <= timer_q - 1'b1;
               end
            end

            default: begin
               state_q <= IDLE;
               tx_q    <= 1'b1;
            end
         endcase
      end
   end

   assign tx       = tx_q;
   assign txbusy   = (state_q != IDLE);
   assign txfinish = (state_q == IDLE) && (count_q == '0);

endmodule

// File: tb/tb_uart_transmit.sv
// -----------------------------------------------------------------------------
// tb_uart_transmit
//
// Two transmitters: u0 (clockperbit=10, stopbits=1, fifodepth=4) and
// u1 (clockperbit=10, stopbits=2, fifodepth=2). A frame-level reference
// model predicts every output on every cycle: accepted bytes wait in a byte
// queue, and when the line is free the next byte expands into a per-cycle
// list of line levels. A line decoder on u0 recovers bytes from the mid-bit
// samples and compares them with the queue of accepted bytes.
// -----------------------------------------------------------------------------
module tb_uart_transmit;

   localparam int CPB0 = 10;
   localparam int SB0  = 1;
   localparam int D0   = 4;
   localparam int CPB1 = 10;
   localparam int SB1  = 2;
   localparam int D1   = 2;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic [7:0] td [2];
   logic       ts [2];
   logic       tx_w [2];
   logic       busy_w [2];
   logic       ready_w [2];
   logic       fin_w [2];

   uart_transmit #(.clockperbit(CPB0), .stopbits(SB0), .fifodepth(D0)) u0 (
      .clock    (clock),
      .reset    (reset),
      .txdata   (td[0]),
      .txstart  (ts[0]),
      .txready  (ready_w[0]),
      .tx       (tx_w[0]),
      .txbusy   (busy_w[0]),
      .txfinish (fin_w[0])
   );

   uart_transmit #(.clockperbit(CPB1), .stopbits(SB1), .fifodepth(D1)) u1 (
      .clock    (clock),
      .reset    (reset),
      .txdata   (td[1]),
      .txstart  (ts[1]),
      .txready  (ready_w[1]),
      .tx       (tx_w[1]),
      .txbusy   (busy_w[1]),
      .txfinish (fin_w[1])
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int cpb_of(input int i);
      return (i == 0) ? CPB0 : CPB1;
   endfunction
   function automatic int sb_of(input int i);
      return (i == 0) ? SB0 : SB1;
   endfunction
   function automatic int depth_of(input int i);
      return (i == 0) ? D0 : D1;
   endfunction

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   logic [7:0] m_fifo [2][$];
   bit         m_line [2][$];
   logic       m_tx [2]   = '{1'b1, 1'b1};
   logic       m_busy [2] = '{1'b0, 1'b0};
   logic [7:0] exp_q [$];

   task automatic model_step(input int i);
      bit         acc;
      logic [7:0] b;
      acc = ts[i] && (m_fifo[i].size() < depth_of(i));
      if ((m_line[i].size() == 0) && (m_fifo[i].size() != 0)) begin
         b = m_fifo[i].pop_front();
         for (int c = 0; c < cpb_of(i); c++) m_line[i].push_back(1'b0);
         for (int k = 0; k < 8; k++)
            for (int c = 0; c < cpb_of(i); c++) m_line[i].push_back(b[k]);
         for (int c = 0; c < cpb_of(i) * sb_of(i); c++) m_line[i].push_back(1'b1);
      end
      if (m_line[i].size() != 0) begin
         m_tx[i]   = m_line[i].pop_front();
         m_busy[i] = 1'b1;
      end else begin
         m_tx[i]   = 1'b1;
         m_busy[i] = 1'b0;
      end
      if (acc) begin
         m_fifo[i].push_back(td[i]);
         if (i == 0) exp_q.push_back(td[i]);
      end
   endtask

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            m_fifo[i].delete();
            m_line[i].delete();
            m_tx[i]   = 1'b1;
            m_busy[i] = 1'b0;
         end
         exp_q.delete();
      end else begin
         for (int i = 0; i < 2; i++) model_step(i);
      end
   end

   // Every-cycle comparison, away from the active edge.
   always @(negedge clock) begin
      for (int i = 0; i < 2; i++) begin
         check($sformatf("tx%0d", i), tx_w[i], m_tx[i]);
         check($sformatf("busy%0d", i), busy_w[i], m_busy[i]);
         check($sformatf("ready%0d", i), ready_w[i], m_fifo[i].size() != depth_of(i));
         check($sformatf("finish%0d", i), fin_w[i], !m_busy[i] && (m_fifo[i].size() == 0));
      end
   end

   // ---------------------------------------------------------------------------
   // Line decoder on u0 with scoreboard against the accepted-byte queue
   // ---------------------------------------------------------------------------
   bit         dec_active = 1'b0;
   int         dec_cnt    = 0;
   int         dec_count  = 0;
   logic [7:0] dec_byte   = '0;

   always @(negedge clock or negedge reset) begin
      int k;
      if (!reset) begin
         dec_active = 1'b0;
      end else if (!dec_active) begin
         if (tx_w[0] === 1'b0) begin
            dec_active = 1'b1;
            dec_cnt    = 0;
         end
      end else begin
         dec_cnt++;
         if ((dec_cnt >= CPB0 + CPB0 / 2) && ((dec_cnt - CPB0 / 2) % CPB0 == 0)) begin
            k = (dec_cnt - CPB0 / 2) / CPB0;
            if (k <= 8) begin
               dec_byte[k-1] = tx_w[0];
            end else begin
               check("dec_stop_bit", tx_w[0], 1);
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL dec_unexpected_byte actual=%02h expected=none", dec_byte);
               end else begin
                  checks--;
                  check("dec_byte", dec_byte, exp_q.pop_front());
               end
               dec_count++;
               dec_active = 1'b0;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic wait_idle(input string name, input int bound);
      int n = 0;
      while (!(fin_w[0] && fin_w[1]) && (n < bound)) begin
         @(negedge clock);
         n++;
      end
      check(name, fin_w[0] && fin_w[1], 1);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      logic [9:0]  pat;
      logic [10:0] pat2;
      logic [7:0]  b2b [3];
      logic [7:0]  fb  [4];
      int          n;
      int          gaps;
      int          dc0;
      int          rate;

      b2b = '{8'hA5, 8'h0F, 8'hFF};
      fb  = '{8'h11, 8'h22, 8'h33, 8'h44};

      reset = 1'b0;
      ts[0] = 1'b0; ts[1] = 1'b0;
      td[0] = 8'h00; td[1] = 8'h00;
      repeat (3) @(negedge clock);
      check("rst_tx", tx_w[0], 1);
      check("rst_busy", busy_w[0], 0);
      check("rst_ready", ready_w[0], 1);
      check("rst_finish", fin_w[0], 1);
      reset = 1'b1;
      repeat (2) @(negedge clock);

      // Single byte 0x55
      @(negedge clock); ts[0] = 1'b1; td[0] = 8'h55;
      @(negedge clock); ts[0] = 1'b0; td[0] = 8'($urandom);
      check("single_tx_before_fall", tx_w[0], 1);
      check("single_finish_drop", fin_w[0], 0);
      @(negedge clock);
      check("single_tx_fall", tx_w[0], 0);
      pat = {1'b1, 8'h55, 1'b0};
      for (int k = 1; k <= 100; k++) begin
         @(negedge clock);
         td[0] = 8'($urandom);
         if (k % 10 == 5) check($sformatf("single_bit%0d", k / 10), tx_w[0], pat[k/10]);
         if (k == 99) check("single_finish_last_stop", fin_w[0], 0);
         if (k == 100) check("single_finish_rise", fin_w[0], 1);
      end

      // Back-to-back 0xA5, 0x0F, 0xFF
      wait_idle("idle_before_b2b", 50);
      for (int j = 0; j < 3; j++) begin
         @(negedge clock); ts[0] = 1'b1; td[0] = b2b[j];
         if (j == 2) check("b2b_fall", tx_w[0], 0);
      end
      @(negedge clock); ts[0] = 1'b0;
      n = 1; gaps = 0;
      while (!fin_w[0] && (n < 400)) begin
         if (!busy_w[0]) gaps++;
         @(negedge clock);
         n++;
      end
      check("b2b_total_cycles", n, 300);
      check("b2b_idle_gaps", gaps, 0);

      // Full FIFO: one byte in flight, four queued, fifth dropped
      wait_idle("idle_before_full", 50);
      dc0 = dec_count;
      @(negedge clock); ts[0] = 1'b1; td[0] = 8'hC3;
      @(negedge clock); ts[0] = 1'b0;
      @(negedge clock);
      for (int j = 0; j < 4; j++) begin
         @(negedge clock); ts[0] = 1'b1; td[0] = fb[j];
      end
      @(negedge clock);
      check("full_ready_low", ready_w[0], 0);
      td[0] = 8'hEE;
      @(negedge clock); ts[0] = 1'b0;
      check("full_ready_still_low", ready_w[0], 0);
      wait_idle("idle_after_full", 700);
      check("full_frames_decoded", dec_count - dc0, 5);

      // Reset during data bit 3 of 0x00
      wait_idle("idle_before_reset", 50);
      @(negedge clock); ts[0] = 1'b1; td[0] = 8'h00;
      @(negedge clock); ts[0] = 1'b0;
      @(negedge clock);
      check("rstmid_fall", tx_w[0], 0);
      repeat (44) @(negedge clock);
      check("rstmid_line_low", tx_w[0], 0);
      #2 reset = 1'b0;
      #1;
      check("rstmid_tx", tx_w[0], 1);
      check("rstmid_busy", busy_w[0], 0);
      check("rstmid_ready", ready_w[0], 1);
      check("rstmid_finish", fin_w[0], 1);
      @(negedge clock);
      @(negedge clock); reset = 1'b1;
      dc0 = dec_count;
      @(negedge clock); ts[0] = 1'b1; td[0] = 8'h3C;
      @(negedge clock); ts[0] = 1'b0;
      wait_idle("idle_after_rstmid", 150);
      check("rstmid_new_frame", dec_count - dc0, 1);

      // stopbits=2 on u1: 0x81 then queued 0x42
      @(negedge clock); ts[1] = 1'b1; td[1] = 8'h81;
      @(negedge clock); td[1] = 8'h42;
      @(negedge clock); ts[1] = 1'b0;
      check("sb2_fall", tx_w[1], 0);
      pat2 = {2'b11, 8'h81, 1'b0};
      for (int k = 1; k <= 220; k++) begin
         @(negedge clock);
         if ((k < 110) && (k % 10 == 5)) check($sformatf("sb2_bit%0d", k / 10), tx_w[1], pat2[k/10]);
         if (k == 109) check("sb2_stop_end", tx_w[1], 1);
         if (k == 110) check("sb2_second_start", tx_w[1], 0);
         if (k == 219) check("sb2_finish_last", fin_w[1], 0);
         if (k == 220) check("sb2_finish_rise", fin_w[1], 1);
      end

      // Randomized traffic on both instances at three offered rates
      for (int ph = 0; ph < 3; ph++) begin
         rate = (ph == 0) ? 60 : ((ph == 1) ? 3 : 20);
         for (int c = 0; c < 1500; c++) begin
            @(negedge clock);
            ts[0] = ($urandom_range(0, rate) == 0);
            ts[1] = ($urandom_range(0, rate) == 0);
            td[0] = 8'($urandom);
            td[1] = 8'($urandom);
         end
      end
      @(negedge clock); ts[0] = 1'b0; ts[1] = 1'b0;
      wait_idle("idle_after_random", 1500);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
